// File: rtl/adbg_syncreg_arb_pkg.sv
// Shared types and constants for the synchronising-register channel arbiter.
// Optional timeout monitor is enabled by defining ADBG_SYNCREG_ARB_TIMEOUT_EN.
package adbg_syncreg_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  localparam int PHASE_BIT = 3;
  localparam int PAYLOAD_W = 3;

endpackage

// File: rtl/adbg_syncreg_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or above rr_ptr, wrapping.
module adbg_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   winner,
  output logic            any_req
);

  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    any_req = |req;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int j = NREQ - 1; j >= 0; j--) begin
      idx = (int'(rr_ptr) + j) % NREQ;
      if (req[idx]) begin
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/adbg_syncreg_arb.sv
// Round-robin arbiter sequencing 3-bit payloads over one 4-bit CLKA->CLKB sync register.
// Define ADBG_SYNCREG_ARB_TIMEOUT_EN to build the WAIT-state timeout monitor.
module adbg_syncreg_arb
  import adbg_syncreg_arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        CLKA,
  input  logic                        RST,
  input  logic [NREQ-1:0]             REQ_VALID,
  input  logic [PAYLOAD_W*NREQ-1:0]   REQ_DATA,
  output logic [NREQ-1:0]             REQ_DONE,
  output logic [3:0]                  SYNC_DATA,
  input  logic [3:0]                  SYNC_ECHO,
  output logic                        BUSY,
  input  logic                        ERR_CLR,
  output logic                        TIMEOUT_ERR,
  output logic                        dbg_state
);

  localparam int IW = $clog2(NREQ);

  // Handshake: REQ_VALID[i] is held until REQ_DONE[i] pulses for one cycle;
  // the payload is sampled only on the grant edge.
  arb_state_t      state, state_next;
  logic            do_grant, do_done;
  logic            phase;
  logic [IW-1:0]   rr_ptr, gnt, winner;
  logic            any_req;
  logic [NREQ-1:0] req_done;
  logic [3:0]      sync_data;

  adbg_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req     (REQ_VALID),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge CLKA or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_done    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          do_grant   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // The phase bit makes a stale echo of the previous word mismatch.
        if (SYNC_ECHO == sync_data) begin
          do_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLKA or posedge RST) begin
    if (RST) begin
      sync_data <= '0;
      phase     <= 1'b0;
      rr_ptr    <= '0;
      gnt       <= '0;
      req_done  <= '0;
    end else begin
      req_done <= '0;
      if (do_grant) begin
        gnt       <= winner;
        sync_data <= {~phase, REQ_DATA[int'(winner)*PAYLOAD_W +: PAYLOAD_W]};
        phase     <= ~phase;
      end
      if (do_done) begin
        req_done <= NREQ'(1) << gnt;
        rr_ptr   <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);
      end
    end
  end

  assign REQ_DONE  = req_done;
  assign SYNC_DATA = sync_data;
  assign BUSY      = (state != IDLE);
  assign dbg_state = state;

`ifdef ADBG_SYNCREG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_cnt;
  logic          to_err;
  logic          to_set;

  // Fires only on the cycle the count reaches the limit, so a clear can stick
  // while the channel is still stuck in WAIT.
  assign to_set = (state == WAIT) && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLKA or posedge RST) begin
    if (RST) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if (do_grant) begin
        to_cnt <= '0;
      end else if ((state == WAIT) && (to_cnt != CW'(TIMEOUT_CYCLES))) begin
        to_cnt <= to_cnt + CW'(1);
      end
      if (to_set) begin
        to_err <= 1'b1;
      end else if (ERR_CLR) begin
        to_err <= 1'b0;
      end
    end
  end

  assign TIMEOUT_ERR = to_err;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ERR_CLR ^ (TIMEOUT_CYCLES == 0);
  assign TIMEOUT_ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_adbg_syncreg_arb.sv
// Self-checking bench for adbg_syncreg_arb: echo delay line, transaction-level model, directed + random.
module tb_adbg_syncreg_arb;

  localparam int NREQ = 4;
  localparam int TO   = 8;
`ifdef ADBG_SYNCREG_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic              clka = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_done;
  logic [3:0]        sync_data;
  logic [3:0]        sync_echo;
  logic              busy;
  logic              err_clr;
  logic              timeout_err;
  logic              dbg_state;

  always #5 clka = ~clka;

  adbg_syncreg_arb #(
    .NREQ           (NREQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLKA        (clka),
    .RST         (rst),
    .REQ_VALID   (req_valid),
    .REQ_DATA    (req_data),
    .REQ_DONE    (req_done),
    .SYNC_DATA   (sync_data),
    .SYNC_ECHO   (sync_echo),
    .BUSY        (busy),
    .ERR_CLR     (err_clr),
    .TIMEOUT_ERR (timeout_err),
    .dbg_state   (dbg_state)
  );

  // Loopback channel: SYNC_DATA returns as SYNC_ECHO after echo_dly+1 edges.
  logic [3:0] pipe [8];
  int         echo_dly;
  logic       echo_hold;

  always @(posedge clka or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) pipe[i] <= 4'h0;
    end else if (!echo_hold) begin
      pipe[0] <= sync_data;
      for (int i = 7; i > 0; i--) pipe[i] <= pipe[i-1];
    end
  end

  assign sync_echo = pipe[echo_dly];

  // ---------------- scoreboard / counters ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transfers are timestamps: grant at edge k completes at edge k+2+echo_dly.
  int              edge_n = 0;
  bit              m_busy;
  int              m_gnt, m_ptr, m_nxfer, m_done_edge;
  logic [3:0]      m_word;
  logic [NREQ-1:0] last_done;

  task automatic model_reset();
    m_busy    = 1'b0;
    m_gnt     = 0;
    m_ptr     = 0;
    m_nxfer   = 0;
    m_word    = 4'h0;
    last_done = '0;
    exp_q.delete();
  endtask

  task automatic step();
    logic [NREQ-1:0]   v;
    logic [3*NREQ-1:0] d;
    logic [NREQ-1:0]   exp_done;
    v = req_valid;
    d = req_data;
    @(posedge clka);
    edge_n++;
    exp_done = '0;
    if (m_busy && edge_n == m_done_edge) begin
      exp_done[m_gnt] = 1'b1;
      m_busy          = 1'b0;
      m_ptr           = (m_gnt + 1) % NREQ;
    end else if (!m_busy && v != '0) begin
      for (int j = 0; j < NREQ; j++) begin
        if (v[(m_ptr + j) % NREQ]) begin
          m_gnt = (m_ptr + j) % NREQ;
          break;
        end
      end
      // First word after reset carries phase 1, then alternates.
      m_word      = {(m_nxfer % 2 == 0), d[m_gnt*3 +: 3]};
      m_nxfer++;
      m_busy      = 1'b1;
      m_done_edge = edge_n + 2 + echo_dly;
      exp_q.push_back(m_word);
    end
    last_done = exp_done;
    #1;
    check("req_done", req_done, exp_done);
    check("busy", busy, m_busy);
    check("dbg_state", dbg_state, m_busy);
    check("sync_data", sync_data, m_word);
    check("timeout_err", timeout_err, 0);
    if (req_done != '0) begin
      check("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("sb_word", sync_data, exp_q.pop_front());
    end
  endtask

  task automatic wait_done(input string tag, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (req_done != '0) seen = 1'b1;
    end
    check(tag, seen, 1);
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    err_clr   = 1'b0;
    echo_hold = 1'b0;
    repeat (2) @(posedge clka);
    @(negedge clka);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  int         n;
  int         seq_got [5];
  int         seq_exp [5];
  logic [4:0] ph_got;
  logic [4:0] ph_exp;
  bit         found;

  initial begin
    echo_dly = 0;
    reset_dut();
    #1;
    check("rst_sync_data", sync_data, 4'h0);
    check("rst_busy", busy, 0);
    check("rst_done", req_done, 0);
    check("rst_timeout", timeout_err, 0);

    // Single request, echo after 6 edges.
    echo_dly      = 5;
    req_valid     = 4'b0001;
    req_data[2:0] = 3'b101;
    step();
    check("t1_word", sync_data, 4'b1101);
    wait_done("t1_seen", n);
    req_valid = '0;
    check("t1_done", req_done, 4'b0001);
    check("t1_busy", busy, 0);
    check("t1_lat", n, 7);
    step();
    check("t1_pulse_len", req_done, 0);

    // Everyone requesting: strict rotation, alternating phase.
    reset_dut();
    echo_dly  = 2;
    req_valid = 4'b1111;
    req_data  = 12'($urandom);
    for (int k = 0; k < 5; k++) begin
      wait_done("t2_seen", n);
      seq_got[k] = onehot_idx(req_done);
      ph_got[k]  = sync_data[3];
    end
    req_valid = '0;
    seq_exp = '{0, 1, 2, 3, 0};
    ph_exp  = 5'b10101;
    for (int k = 0; k < 5; k++) check("t2_order", seq_got[k], seq_exp[k]);
    check("t2_phase", ph_got, ph_exp);

    // Same payload twice: stale echo must not complete the second word.
    reset_dut();
    echo_dly      = 3;
    req_valid     = 4'b0100;
    req_data[8:6] = 3'b011;
    wait_done("t3_seen1", n);
    check("t3_word1", sync_data, 4'b1011);
    wait_done("t3_seen2", n);
    req_valid = '0;
    check("t3_word2", sync_data, 4'b0011);
    check("t3_lat2", n, 6);

    // Reset in WAIT.
    reset_dut();
    echo_dly      = 4;
    req_valid     = 4'b0010;
    req_data[5:3] = 3'b111;
    repeat (3) step();
    rst       = 1'b1;
    req_valid = '0;
    #1;
    check("t4_sync_data", sync_data, 4'h0);
    check("t4_busy", busy, 0);
    check("t4_done", req_done, 0);
    @(negedge clka);
    rst = 1'b0;
    model_reset();
    repeat (6) step();
    req_valid     = 4'b0010;
    req_data[5:3] = 3'b010;
    step();
    check("t4_phase", sync_data, 4'b1010);
    wait_done("t4_seen", n);
    req_valid = '0;

    // Requester drops REQ_VALID after grant.
    reset_dut();
    echo_dly        = 3;
    req_valid       = 4'b1000;
    req_data[11:9]  = 3'b110;
    step();
    req_valid = '0;
    req_data  = 12'h249;
    wait_done("t5_seen", n);
    check("t5_done", req_done, 4'b1000);
    check("t5_word", sync_data, 4'b1110);

    // Withheld echo: timeout flag, set wins over clear, late completion, clear.
    reset_dut();
    echo_dly      = 1;
    echo_hold     = 1'b1;
    req_valid     = 4'b0010;
    req_data[5:3] = 3'b100;
    @(posedge clka); #1;
    check("to_busy", busy, 1);
    req_valid = '0;
    err_clr   = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clka); #1;
      check("to_early", timeout_err, 0);
    end
    @(posedge clka); #1;
    check("to_set", timeout_err, TO_EN);
    err_clr   = 1'b0;
    echo_hold = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clka); #1;
      if (req_done != '0) begin
        found = 1'b1;
        check("to_done", req_done, 4'b0010);
      end
    end
    check("to_found", found, 1);
    check("to_sticky", timeout_err, TO_EN);
    err_clr = 1'b1;
    @(posedge clka); #1;
    err_clr = 1'b0;
    check("to_clr", timeout_err, 0);

    // Randomised traffic across several echo delays.
    for (int seg = 0; seg < 3; seg++) begin
      reset_dut();
      echo_dly = $urandom_range(0, 4);
      for (int c = 0; c < 250; c++) begin
        step();
        err_clr = 1'($urandom_range(0, 1));
        for (int i = 0; i < NREQ; i++) begin
          if (last_done[i]) begin
            req_valid[i] = 1'($urandom_range(0, 1));
            req_data[i*3 +: 3] = 3'($urandom);
          end else if (!req_valid[i]) begin
            req_data[i*3 +: 3] = 3'($urandom);
            if ($urandom_range(0, 4) == 0) req_valid[i] = 1'b1;
          end else if (m_busy && i == m_gnt) begin
            req_data[i*3 +: 3] = 3'($urandom);
            if ($urandom_range(0, 5) == 0) req_valid[i] = 1'b0;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adbg_syncreg_arb.md
# adbg_syncreg_arb

Round-robin arbiter and sequencer sharing one 4-bit CLKA→CLKB synchronising register channel among NREQ requesters in the CLKA domain. It frames each 3-bit payload with a phase bit so consecutive words always differ and are always transferred. Completion is confirmed by comparing against an echo of the destination register, returned to CLKA through a second sync register.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 255: WAIT-state cycles before the timeout flag sets. Used only with the timeout feature.
- CLKA  in  1: source clock. All logic is in this domain.
- RST  in  1: asynchronous, active-high reset.
- REQ_VALID  in  NREQ: per-requester request. Held until REQ_DONE.
- REQ_DATA  in  3*NREQ: payloads; requester i owns bits [3i+2:3i].
- REQ_DONE  out  NREQ: one-cycle completion pulse for the granted requester.
- SYNC_DATA  out  4: word to the forward sync register DATA_IN; {phase, payload[2:0]}.
- SYNC_ECHO  in  4: destination-domain register value, synchronised back to CLKA.
- BUSY  out  1: high whenever the state is not IDLE.
- ERR_CLR  in  1: clears TIMEOUT_ERR.
- TIMEOUT_ERR  out  1: sticky timeout flag.

## Operation
- States are IDLE and WAIT.
- **IDLE**
  - If any REQ_VALID bit is set, pick a winner: search upward from rr_ptr, wrapping modulo NREQ.
  - Register the winner's index in gnt.
  - Load SYNC_DATA <= {~phase, REQ_DATA[gnt]} and set phase <= ~phase.
  - Clear the timeout counter and go to WAIT.
- **WAIT**
  - Payload is already captured. Changes to REQ_DATA or REQ_VALID have no effect.
  - When SYNC_ECHO == SYNC_DATA on all 4 bits, pulse REQ_DONE[gnt], set rr_ptr <= (gnt+1) mod NREQ, and return to IDLE.
- **Echo matching**
  - A stale echo of the previous word carries the opposite phase bit, so it never matches.
  - Only the full 4-bit equality counts as completion.
- **Requester rules**
  - A requester that drops REQ_VALID after being granted still receives REQ_DONE.
  - A requester that keeps REQ_VALID high after REQ_DONE is a new request. Round-robin order gives the others precedence.
- **Reset values**
  - SYNC_DATA=4'b0000, phase=0, rr_ptr=0, gnt=0, state=IDLE.
  - REQ_DONE=0, BUSY=0, TIMEOUT_ERR=0, counter=0.
  - The all-zero SYNC_DATA matches the sync registers' reset contents, so the echo is consistent from reset.
- **Reset mid-transfer**: all state returns to reset values immediately. The whole channel must be reset by the same RST.

## Timing
- IDLE grant to SYNC_DATA update: 1 CLKA edge.
- REQ_DONE is asserted in the cycle after the edge on which the match was sampled. It lasts exactly 1 cycle, and the state is IDLE in that same cycle.
- Back-to-back transfers: a new grant can occur at the edge ending the REQ_DONE cycle. The minimum period is 2 cycles plus the echo round-trip.
- Only one bit of REQ_DONE is ever high.
- BUSY is high from the grant edge until the completion edge.

## Configuration
- Macro: ADBG_SYNCREG_ARB_TIMEOUT_EN.
- **Defined**:
  - A saturating counter of width $clog2(TIMEOUT_CYCLES+1) increments every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES, TIMEOUT_ERR sets and stays set.
  - The FSM keeps waiting; a late echo still completes normally.
  - ERR_CLR clears the flag. If ERR_CLR and the set condition occur in the same cycle, set wins.
- **Undefined**: there is no counter; TIMEOUT_ERR is tied to 0 and ERR_CLR is ignored.

## Structure
- Package adbg_syncreg_arb_pkg holds:
  - the state enum typedef (IDLE, WAIT);
  - localparams PHASE_BIT=3 and PAYLOAD_W=3.
- Sub-module adbg_rr_pick: combinational round-robin picker. Inputs are the request vector and rr_ptr; outputs are the winner index and an any-request flag.

## Test plan
- **Reset then single request**: REQ_VALID=4'b0001, REQ_DATA[2:0]=3'b101 → SYNC_DATA=4'b1101 one edge later. Echo returned after 6 cycles → REQ_DONE=4'b0001 for one cycle, BUSY falls.
- **All four requesting, echo looped with fixed delay**: grants in order 0,1,2,3,0. The phase bit alternates 1,0,1,0,1.
- **Same payload twice from requester 2 (3'b011)**: words 4'b1011 then 4'b0011. The second is not completed by the stale 4'b1011 echo.
- **Reset mid-transfer**: RST asserted in WAIT → SYNC_DATA=0, BUSY=0, no REQ_DONE. The next request starts with phase 1.
- **With ADBG_SYNCREG_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8**: echo withheld → TIMEOUT_ERR rises after 8 WAIT cycles. A later echo gives REQ_DONE; ERR_CLR drops the flag.
- **Requester drops REQ_VALID in WAIT**: REQ_DONE still pulses for it with the originally captured payload.
